// File: rtl/wpb_pkg.sv
`default_nettype none
// ==========================================================================
// wpb_pkg: shared types, constants and helpers for weight_pingpong_buffer
// Rev 1.0
// ==========================================================================
package wpb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        AR     = 2'd1,
        R_DATA = 2'd2
    } fill_state_e;

    localparam logic [3:0] AXI_BURST_INCR = 4'b0001;

    function automatic int unsigned beats(input int unsigned remaining, input int unsigned burst);
        return (remaining < burst) ? remaining : burst;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wpb_bank.sv
`default_nettype none
// ==========================================================================
// wpb_bank: TAPS x NCH x DW weight register bank, one write port, one tap read
// Rev 1.0
// ==========================================================================
module wpb_bank #(
    parameter int DW     = 32,
    parameter int TAPS   = 9,
    parameter int NCH    = 4,
    parameter int TAP_W  = 4,
    parameter int LANE_W = 2
) (
    input  logic                clk,
    input  logic                we,
    input  logic [TAP_W-1:0]    wr_tap,
    input  logic [LANE_W-1:0]   wr_lane,
    input  logic [DW-1:0]       wr_data,
    input  logic [TAP_W-1:0]    rd_tap,
    output logic [NCH*DW-1:0]   rd_data
);

    logic [DW-1:0] r_mem [TAPS][NCH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_tap][wr_lane] <= wr_data;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        assign rd_data[c*DW +: DW] = r_mem[rd_tap][c];
    end

endmodule
`default_nettype wire

// File: rtl/weight_pingpong_buffer.sv
`default_nettype none
// ==========================================================================
// weight_pingpong_buffer: ping-pong depthwise weight buffer filled by AXI INCR bursts
// Rev 1.0
// ==========================================================================
module weight_pingpong_buffer
    import wpb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int KSIZE = 3,
    parameter int NCH   = 4,
    parameter int BURST = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                weight_load,
    input  logic                init_addr_en,
    input  logic [AW-1:0]       init_addr,
    output logic                load_busy,
    output logic [AW-1:0]       araddr,
    output logic [7:0]          arlen,
    output logic [3:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DW-1:0]       rdata,
    input  logic                rvalid,
    output logic                rready,
    input  logic                rlast,
    input  logic                dw_ready,
    output logic                dw_valid,
    output logic [NCH*DW-1:0]   dw_out,
    output logic                dw_last,
    input  logic                dw_comp,
    output logic                err
);

    localparam int TAPS   = KSIZE * KSIZE;
    localparam int WORDS  = TAPS * NCH;
    localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int LANE_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W  = $clog2(WORDS + 1);
    localparam logic [AW-1:0] STRIDE = AW'(DW / 8);

    fill_state_e        r_state;
    fill_state_e        w_state_nxt;
    logic [AW-1:0]      r_ptr;
    logic [CNT_W-1:0]   r_remaining;
    logic [8:0]         r_burst_len;
    logic [8:0]         r_beat_cnt;
    logic [TAP_W-1:0]   r_wr_tap;
    logic [LANE_W-1:0]  r_wr_lane;
    logic [TAP_W-1:0]   r_rd_tap;
    logic               r_front_sel;
    logic               r_front_valid;
    logic               r_back_valid;
    logic               r_err;

    logic [8:0]         w_beats;
    logic               w_beat;
    logic               w_counted_last;
    logic               w_fill_done;
    logic               w_release;
    logic               w_front_nxt;
    logic               w_back_nxt;
    logic               w_swap;
    logic               w_start;
    logic [NCH*DW-1:0]  w_bank_rd [2];

    assign w_beats        = 9'(beats(32'(r_remaining), 32'(BURST)));
    assign w_beat         = (r_state == R_DATA) && rvalid;
    assign w_counted_last = (r_beat_cnt == r_burst_len - 9'd1);
    assign w_fill_done    = w_beat && (r_wr_tap == TAP_W'(TAPS - 1)) && (r_wr_lane == LANE_W'(NCH - 1));
    assign w_release      = dw_comp && r_front_valid;

    // A bank that just completed (or was already waiting) moves to the front whenever the front is empty
    assign w_front_nxt    = r_front_valid && !w_release;
    assign w_back_nxt     = r_back_valid || w_fill_done;
    assign w_swap         = !w_front_nxt && w_back_nxt;

    assign load_busy      = (r_state != IDLE) || (r_front_valid && r_back_valid);
    assign w_start        = weight_load && !load_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        araddr      = '0;
        arlen       = 8'd0;
        rready      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                araddr  = r_ptr;
                arlen   = 8'(w_beats - 9'd1);
                if (arready) begin
                    w_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                rready = 1'b1;
                if (w_beat && w_counted_last) begin
                    w_state_nxt = (r_remaining != '0) ? AR : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_burst_len <= '0;
            r_beat_cnt  <= '0;
            r_wr_tap    <= '0;
            r_wr_lane   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == IDLE && w_start) begin
                if (init_addr_en) begin
                    r_ptr <= init_addr;
                end
                r_remaining <= CNT_W'(WORDS);
                r_wr_tap    <= '0;
                r_wr_lane   <= '0;
            end
            if (r_state == AR && arready) begin
                r_remaining <= r_remaining - CNT_W'(w_beats);
                r_burst_len <= w_beats;
                r_beat_cnt  <= '0;
            end
            if (w_beat) begin
                r_ptr      <= r_ptr + STRIDE;
                r_beat_cnt <= r_beat_cnt + 9'd1;
                if (r_wr_lane == LANE_W'(NCH - 1)) begin
                    r_wr_lane <= '0;
                    r_wr_tap  <= r_wr_tap + TAP_W'(1);
                end else begin
                    r_wr_lane <= r_wr_lane + LANE_W'(1);
                end
                // The beat count, not rlast, decides where the burst ends
                if (rlast != w_counted_last) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front_sel   <= 1'b0;
            r_front_valid <= 1'b0;
            r_back_valid  <= 1'b0;
            r_rd_tap      <= '0;
        end else begin
            if (w_swap) begin
                r_front_sel   <= !r_front_sel;
                r_front_valid <= 1'b1;
                r_back_valid  <= 1'b0;
            end else begin
                r_front_valid <= w_front_nxt;
                r_back_valid  <= w_back_nxt;
            end
            if (w_release) begin
                r_rd_tap <= '0;
            end else if (r_front_valid && dw_ready) begin
                r_rd_tap <= (r_rd_tap == TAP_W'(TAPS - 1)) ? '0 : r_rd_tap + TAP_W'(1);
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        wpb_bank #(
            .DW     (DW),
            .TAPS   (TAPS),
            .NCH    (NCH),
            .TAP_W  (TAP_W),
            .LANE_W (LANE_W)
        ) u_bank (
            .clk     (clk),
            .we      (w_beat && (r_front_sel != 1'(i))),
            .wr_tap  (r_wr_tap),
            .wr_lane (r_wr_lane),
            .wr_data (rdata),
            .rd_tap  (r_rd_tap),
            .rd_data (w_bank_rd[i])
        );
    end

    assign arburst  = AXI_BURST_INCR;
    assign dw_valid = r_front_valid;
    assign dw_out   = r_front_valid ? w_bank_rd[r_front_sel] : '0;
    assign dw_last  = r_front_valid && (r_rd_tap == TAP_W'(TAPS - 1));
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_weight_pingpong_buffer.sv
`default_nettype none
// ==========================================================================
// tb_weight_pingpong_buffer: directed self-checking bench for weight_pingpong_buffer
// Rev 1.0
// ==========================================================================
module tb_weight_pingpong_buffer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int KSIZE = 3;
    localparam int NCH   = 4;
    localparam int BURST = 32;
    localparam int TAPS  = KSIZE * KSIZE;
    localparam int WORDS = TAPS * NCH;

    logic              clk;
    logic              rst_n;
    logic              weight_load;
    logic              init_addr_en;
    logic [AW-1:0]     init_addr;
    logic              load_busy;
    logic [AW-1:0]     araddr;
    logic [7:0]        arlen;
    logic [3:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic              rvalid;
    logic              rready;
    logic              rlast;
    logic              dw_ready;
    logic              dw_valid;
    logic [NCH*DW-1:0] dw_out;
    logic              dw_last;
    logic              dw_comp;
    logic              err;

    weight_pingpong_buffer #(
        .DW(DW), .AW(AW), .KSIZE(KSIZE), .NCH(NCH), .BURST(BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .weight_load(weight_load), .init_addr_en(init_addr_en),
        .init_addr(init_addr), .load_busy(load_busy), .araddr(araddr), .arlen(arlen),
        .arburst(arburst), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid),
        .rready(rready), .rlast(rlast), .dw_ready(dw_ready), .dw_valid(dw_valid), .dw_out(dw_out),
        .dw_last(dw_last), .dw_comp(dw_comp), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [127:0] tap_word(input logic [31:0] base, input int t);
        logic [127:0] v;
        for (int c = 0; c < NCH; c++) begin
            v[c*32 +: 32] = pat(base + 32'((t * NCH + c) * 4));
        end
        return v;
    endfunction

    task automatic wait_ar();
        int n = 0;
        while (!arvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Serves a full bank fill as an AXI read slave and checks the address channel
    task automatic fill(input logic [31:0] base, input bit stall, input int early_burst);
        int rem  = WORDS;
        int widx = 0;
        int b    = 0;
        int nb;
        logic [31:0] exp_addr;
        while (rem > 0) begin
            nb = (rem > BURST) ? BURST : rem;
            exp_addr = base + 32'(widx * 4);
            wait_ar();
            check("arvalid", 128'(arvalid), 128'(1));
            check("araddr", 128'(araddr), 128'(exp_addr));
            check("arlen", 128'(arlen), 128'(nb - 1));
            check("arburst", 128'(arburst), 128'(4'b0001));
            if (stall) begin
                repeat ($urandom_range(1, 3)) begin
                    arready = 1'b0;
                    @(negedge clk);
                    check("ar_stable_addr", 128'(araddr), 128'(exp_addr));
                    check("ar_stable_len", 128'(arlen), 128'(nb - 1));
                end
            end
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0;
            for (int k = 0; k < nb; k++) begin
                if (stall) begin
                    while ($urandom_range(0, 1) == 0) begin
                        rvalid = 1'b0;
                        @(negedge clk);
                    end
                end
                check("rready", 128'(rready), 128'(1));
                rvalid = 1'b1;
                rdata  = pat(base + 32'(widx * 4));
                rlast  = (b == early_burst) ? (k == nb - 2) : (k == nb - 1);
                @(negedge clk);
                widx++;
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            rem -= nb;
            b++;
        end
    endtask

    task automatic start_load(input bit use_init, input logic [31:0] addr);
        weight_load  = 1'b1;
        init_addr_en = use_init;
        init_addr    = addr;
        @(negedge clk);
        weight_load  = 1'b0;
        init_addr_en = 1'b0;
    endtask

    task automatic walk_taps(input logic [31:0] base, input string name);
        dw_ready = 1'b1;
        for (int t = 0; t < TAPS; t++) begin
            check(name, dw_out, tap_word(base, t));
            check("walk_last", 128'(dw_last), 128'(t == TAPS - 1));
            @(negedge clk);
        end
        dw_ready = 1'b0;
    endtask

    typedef struct {
        bit          ready;
        bit          comp;
        bit          valid;
        int          tap;
        bit          last;
        bit          busy;
        logic [31:0] base;
    } vec_t;

    vec_t vecs [27];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Replay of bank A (0x100) for 20 beats, release with back bank B (0x190) ready, then empty out
        for (int i = 0; i < 20; i++) begin
            vecs[i] = '{1'b1, 1'b0, 1'b1, i % TAPS, (i % TAPS) == TAPS - 1, 1'b1, 32'h100};
        end
        vecs[20] = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1, 32'h100};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h190};
        vecs[22] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 32'h190};
        vecs[23] = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 32'h190};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0};
        vecs[25] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0};
        vecs[26] = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0};

        rst_n = 1'b0; weight_load = 1'b0; init_addr_en = 1'b0; init_addr = '0;
        arready = 1'b0; rdata = '0; rvalid = 1'b0; rlast = 1'b0;
        dw_ready = 1'b0; dw_comp = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dw_valid", 128'(dw_valid), 128'(0));
        check("rst_load_busy", 128'(load_busy), 128'(0));
        check("rst_arvalid", 128'(arvalid), 128'(0));
        check("rst_rready", 128'(rready), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_dw_out", dw_out, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: first fill from 0x100
        start_load(1'b1, 32'h100);
        check("t1_busy", 128'(load_busy), 128'(1));
        check("t1_no_valid", 128'(dw_valid), 128'(0));
        fill(32'h100, 1'b0, -1);
        check("t1_dw_valid", 128'(dw_valid), 128'(1));
        check("t1_busy_clr", 128'(load_busy), 128'(0));
        check("t1_tap0", dw_out, tap_word(32'h100, 0));

        // 2: continue from the end of the previous fill into the back bank
        start_load(1'b0, 32'hDEAD_0000);
        fill(32'h190, 1'b0, -1);
        check("t2_front_kept", dw_out, tap_word(32'h100, 0));
        check("t2_both_busy", 128'(load_busy), 128'(1));

        // 4: load request while both banks hold data is dropped
        weight_load = 1'b1;
        @(negedge clk);
        weight_load = 1'b0;
        repeat (3) begin
            check("t4_no_arvalid", 128'(arvalid), 128'(0));
            check("t4_busy", 128'(load_busy), 128'(1));
            @(negedge clk);
        end

        // 3 + release: table-driven replay, swap without gap, release to empty
        for (int i = 0; i < 27; i++) begin
            dw_ready = vecs[i].ready;
            dw_comp  = vecs[i].comp;
            check($sformatf("vec%0d_valid", i), 128'(dw_valid), 128'(vecs[i].valid));
            check($sformatf("vec%0d_out", i), dw_out,
                  vecs[i].valid ? tap_word(vecs[i].base, vecs[i].tap) : 128'(0));
            check($sformatf("vec%0d_last", i), 128'(dw_last), 128'(vecs[i].last));
            check($sformatf("vec%0d_busy", i), 128'(load_busy), 128'(vecs[i].busy));
            @(negedge clk);
        end
        dw_ready = 1'b0;
        dw_comp  = 1'b0;

        // 5: stalled handshakes with an early rlast on the second burst
        check("t5_err_pre", 128'(err), 128'(0));
        start_load(1'b1, 32'h300);
        fill(32'h300, 1'b1, 1);
        check("t5_err", 128'(err), 128'(1));
        check("t5_valid", 128'(dw_valid), 128'(1));
        walk_taps(32'h300, "t5_data");
        dw_comp = 1'b1;
        @(negedge clk);
        dw_comp = 1'b0;
        check("t5_released", 128'(dw_valid), 128'(0));

        // 6: asynchronous reset in the middle of a data burst
        start_load(1'b1, 32'h400);
        wait_ar();
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rvalid = 1'b1;
            rdata  = pat(32'h400 + 32'(k * 4));
            @(negedge clk);
        end
        rvalid = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("t6_rready", 128'(rready), 128'(0));
        check("t6_busy", 128'(load_busy), 128'(0));
        check("t6_err", 128'(err), 128'(0));
        check("t6_arvalid", 128'(arvalid), 128'(0));
        check("t6_dw_valid", 128'(dw_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_load(1'b1, 32'h200);
        fill(32'h200, 1'b0, -1);
        check("t6_valid", 128'(dw_valid), 128'(1));
        check("t6_err_after", 128'(err), 128'(0));
        walk_taps(32'h200, "t6_data");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
